jump_physics: RTL and testbench

Parametrised vertical-motion engine for game actors, generalising the T-rex jump logic. Adds configurable geometry and gravity, multi-jump (air jumps), fast-fall scaling, velocity saturation and a landing pulse. Sits between the input/game-control logic and the sprite/collision logic. One instance per actor.

---
 rtl/jump_physics.sv | 213 +++++++++++++++++++++
 tb/tb_jump_physics.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/jump_physics.sv
// jump_physics: per-actor vertical motion engine with gravity accumulator, air jumps,
// fast-fall, velocity saturation and a landing pulse. Optional jump buffer: `define JUMP_BUFFER_EN.
module jump_physics #(
    parameter int POS_W           = 12,
    parameter int VEL_W           = 10,
    parameter int SPEED_W         = 5,
    parameter int GROUND_Y        = 87,
    parameter int GRAVITY         = 6,
    parameter int GRAV_DEN        = 10,
    parameter int INIT_VEL        = -10,
    parameter int SPEED_SHIFT     = 3,
    parameter int MIN_JUMP_HEIGHT = 30,
    parameter int MAX_JUMP_HEIGHT = 30,
    parameter int DROP_VELOCITY   = -5,
    parameter int FAST_FALL_VEL   = 1,
    parameter int FAST_SHIFT      = 1,
    parameter int MAX_FALL_VEL    = 12,
    parameter int MAX_AIR_JUMPS   = 1,
    parameter int BUFFER_TICKS    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               update,
    input  logic [SPEED_W-1:0]                 speed,
    input  logic                               jump,
    input  logic                               duck,
    input  logic                               crash,
    output logic [POS_W-1:0]                   y_pos,
    output logic [VEL_W-1:0]                   velocity,
    output logic [2:0]                         state,
    output logic                               airborne,
    output logic [$clog2(MAX_AIR_JUMPS+1)-1:0] air_jumps_left,
    output logic                               landed
);

    localparam int AJ_W  = $clog2(MAX_AIR_JUMPS + 1);
    localparam int EXT_W = ((POS_W > VEL_W) ? POS_W : VEL_W) + FAST_SHIFT + 1;
    localparam int ACC_W = $clog2(GRAV_DEN + GRAVITY + 1);

    typedef logic signed [EXT_W-1:0] ext_t;

    localparam ext_t GROUND_E   = ext_t'(GROUND_Y);
    localparam ext_t TOP_E      = ext_t'(GROUND_Y - MAX_JUMP_HEIGHT);
    localparam ext_t MIN_E      = ext_t'(GROUND_Y - MIN_JUMP_HEIGHT);
    localparam ext_t DROP_E     = ext_t'(DROP_VELOCITY);
    localparam ext_t INIT_E     = ext_t'(INIT_VEL);
    localparam ext_t MAX_FALL_E = ext_t'(MAX_FALL_VEL);
    localparam logic signed [VEL_W-1:0] FFV_V = VEL_W'(FAST_FALL_VEL);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUNNING   = 3'd1,
        S_RISING    = 3'd2,
        S_FALLING   = 3'd3,
        S_FAST_FALL = 3'd4,
        S_DUCKING   = 3'd5,
        S_CRASHED   = 3'd6
    } state_t;

    state_t                    state_q, state_d;
    logic signed [POS_W-1:0]   y_q, y_d;
    logic signed [VEL_W-1:0]   vel_q, vel_d;
    logic [ACC_W-1:0]          acc_q, acc_d, acc_sum, acc_nx;
    logic [AJ_W-1:0]           ajl_q, ajl_d;
    logic                      landed_q, landed_d;
    logic                      jump_q, jump_rise, carry, landing, jump_end, do_launch, land_tick;
    logic                      buf_go;
    ext_t                      y_ext, vel_ext, vel_g, vel_n, vel_f, disp, y_n, launch_vel, launch_y;

    assign jump_rise = jump & ~jump_q;

    // Candidate physics for this tick; the FSM below decides which parts commit.
    assign acc_sum    = acc_q + ACC_W'(GRAVITY);
    assign carry      = (acc_sum >= ACC_W'(GRAV_DEN));
    assign acc_nx     = carry ? acc_sum - ACC_W'(GRAV_DEN) : acc_sum;
    assign y_ext      = ext_t'(y_q);
    assign vel_ext    = ext_t'(vel_q);
    assign vel_g      = carry ? vel_ext + ext_t'(1) : vel_ext;
    assign vel_n      = (vel_g > MAX_FALL_E) ? MAX_FALL_E : vel_g;
    assign disp       = (state_q == S_FAST_FALL) ? (vel_n <<< FAST_SHIFT) : vel_n;
    assign y_n        = y_ext + disp;
    assign landing    = (y_n >= GROUND_E);
    assign launch_vel = INIT_E - ext_t'(speed >> SPEED_SHIFT);
    assign launch_y   = y_ext + launch_vel;
    assign jump_end   = (vel_n < DROP_E) && ((y_n < TOP_E) || (!jump && (y_n <= MIN_E)));
    assign vel_f      = ((state_q == S_RISING) && jump_end) ? DROP_E : vel_n;

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        vel_d     = vel_q;
        acc_d     = acc_q;
        ajl_d     = ajl_q;
        do_launch = 1'b0;
        land_tick = 1'b0;
        if (update) begin
            if (crash) begin
                state_d = S_CRASHED;
            end else begin
                case (state_q)
                    S_IDLE: if (jump_rise) state_d = S_RUNNING;
                    S_RUNNING: begin
                        if (jump_rise || buf_go) begin
                            do_launch = 1'b1;
                            ajl_d     = AJ_W'(MAX_AIR_JUMPS);
                        end else if (duck) begin
                            state_d = S_DUCKING;
                        end
                    end
                    S_DUCKING: if (!duck) state_d = S_RUNNING;
                    S_RISING, S_FALLING, S_FAST_FALL: begin
                        if (jump_rise && (ajl_q != '0)) begin
                            do_launch = 1'b1;
                            ajl_d     = ajl_q - 1'b1;
                        end else if (landing) begin
                            land_tick = 1'b1;
                            y_d       = POS_W'(GROUND_E);
                            vel_d     = '0;
                            acc_d     = '0;
                            ajl_d     = AJ_W'(MAX_AIR_JUMPS);
                            state_d   = duck ? S_DUCKING : S_RUNNING;
                        end else if (duck && (state_q != S_FAST_FALL)) begin
                            // Entry tick only swaps velocity; displacement starts next tick.
                            vel_d   = FFV_V;
                            state_d = S_FAST_FALL;
                        end else begin
                            y_d   = POS_W'(y_n);
                            vel_d = VEL_W'(vel_f);
                            acc_d = acc_nx;
                            if (state_q == S_FAST_FALL) begin
                                if (!duck) state_d = S_FALLING;
                            end else if ((state_q == S_RISING) && (vel_f >= ext_t'(0))) begin
                                state_d = S_FALLING;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (do_launch) begin
            y_d     = POS_W'(launch_y);
            vel_d   = VEL_W'(launch_vel);
            acc_d   = '0;
            state_d = S_RISING;
        end
        landed_d = land_tick;
    end

`ifdef JUMP_BUFFER_EN
    localparam int BUF_W = $clog2(BUFFER_TICKS + 1);
    logic [BUF_W-1:0] buf_cnt_q, buf_cnt_d;
    logic             buf_pend_q, buf_pend_d, rise_lost, run_launch;

    assign rise_lost  = update && !crash && airborne && jump_rise && (ajl_q == '0);
    assign run_launch = do_launch && (state_q == S_RUNNING);
    assign buf_go     = buf_pend_q;

    always_comb begin
        buf_cnt_d  = buf_cnt_q;
        buf_pend_d = buf_pend_q;
        if (update) begin
            if (buf_cnt_q != '0) buf_cnt_d = buf_cnt_q - 1'b1;
            if (rise_lost) buf_cnt_d = BUF_W'(BUFFER_TICKS);
            if (land_tick) buf_pend_d = (buf_cnt_q != '0);
            if (crash || run_launch) begin
                buf_cnt_d  = '0;
                buf_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_cnt_q  <= '0;
            buf_pend_q <= 1'b0;
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            buf_pend_q <= buf_pend_d;
        end
    end
`else
    assign buf_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            y_q      <= POS_W'(GROUND_E);
            vel_q    <= '0;
            acc_q    <= '0;
            ajl_q    <= AJ_W'(MAX_AIR_JUMPS);
            landed_q <= 1'b0;
            jump_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            acc_q    <= acc_d;
            ajl_q    <= ajl_d;
            landed_q <= landed_d;
            if (update) jump_q <= jump;
        end
    end

    assign y_pos          = y_q;
    assign velocity       = vel_q;
    assign state          = state_q;
    assign airborne       = (state_q == S_RISING) || (state_q == S_FALLING) || (state_q == S_FAST_FALL);
    assign air_jumps_left = ajl_q;
    assign landed         = landed_q;

endmodule

// File: tb/tb_jump_physics.sv
// Directed scoreboard bench for jump_physics: the driver queues hand-computed responses,
// the monitor pops one per update tick (or reset) and checks landed stays low on idle cycles.
module tb_jump_physics;

    logic        clk = 1'b0;
    logic        rst, update, jump, duck, crash;
    logic [4:0]  speed;
    logic [11:0] y_pos;
    logic [9:0]  velocity;
    logic [2:0]  state;
    logic        airborne;
    logic [0:0]  air_jumps_left;
    logic        landed;

    always #5 clk = ~clk;

    jump_physics dut (
        .clk(clk), .rst(rst), .update(update), .speed(speed), .jump(jump), .duck(duck),
        .crash(crash), .y_pos(y_pos), .velocity(velocity), .state(state),
        .airborne(airborne), .air_jumps_left(air_jumps_left), .landed(landed)
    );

    typedef struct { int y; int v; int st; int a; int l; } exp_t;
    localparam int X = 9999;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    logic probe = 1'b0, probe_d = 1'b0, armed = 1'b0;

    // Launch from ground, speed 0, jump held: ticks 2..25 after the launch tick.
    int ys1[24] = '{67, 58, 49, 45, 42, 39, 37, 35, 34, 34, 34, 35, 36, 38, 41, 44, 48, 52, 57, 63, 69, 76, 83, 87};
    int vs1[24] = '{-10, -9, -5, -4, -3, -3, -2, -2, -1, 0, 0, 1, 1, 2, 3, 3, 4, 4, 5, 6, 6, 7, 7, 0};
    // After the ignored third rise: rise to apex then fall.
    int ys2[10] = '{35, 32, 30, 28, 27, 26, 26, 27, 28, 30};
    int vs2[10] = '{-4, -3, -2, -2, -1, -1, 0, 1, 1, 2};
    // Fast-fall descent with duck held, ending in a landing into DUCKING.
    int ys3[8]  = '{36, 42, 48, 56, 64, 74, 86, 87};
    int vs3[8]  = '{2, 3, 3, 4, 4, 5, 6, 0};

    always @(posedge clk) probe_d <= probe;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (probe_d) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL queue_underflow: got a response, expected queue empty");
            end else begin
                mon_e = exp_q.pop_front();
                chk("state", int'(state), mon_e.st);
                chk("airborne", int'(airborne), int'(mon_e.st >= 2 && mon_e.st <= 4));
                chk("landed", int'(landed), mon_e.l);
                if (mon_e.y != X) chk("y_pos", int'($signed(y_pos)), mon_e.y);
                if (mon_e.v != X) chk("velocity", int'($signed(velocity)), mon_e.v);
                if (mon_e.a != X) chk("air_jumps_left", int'(air_jumps_left), mon_e.a);
            end
        end else if (armed) begin
            chk("landed_idle", int'(landed), 0);
        end
    end

    task automatic tick(input logic j, input logic d, input logic c, input int spd,
                        input int y, input int v, input int st, input int a, input int l);
        @(negedge clk);
        jump = j; duck = d; crash = c; speed = 5'(spd);
        update = 1'b1; probe = 1'b1;
        exp_q.push_back('{y, v, st, a, l});
        @(negedge clk);
        update = 1'b0; probe = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; update = 1'b0; jump = 1'b0; duck = 1'b0; crash = 1'b0; speed = '0;
        probe = 1'b1;
        exp_q.push_back('{87, 0, 0, 1, 0});
        @(negedge clk);
        rst = 1'b1; probe = 1'b0;
    endtask

    initial begin
        rst = 1'b0; update = 1'b0; jump = 1'b0; duck = 1'b0; crash = 1'b0; speed = '0;
        do_reset();
        armed = 1'b1;

        // IDLE -> RUNNING, then launch with speed 0 and hold jump through landing.
        tick(1, 0, 0, 0, 87, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 87, 0, 1, 1, 0);
        tick(1, 0, 0, 0, 77, -10, 2, 1, 0);
        for (int i = 0; i < 24; i++)
            tick(1, 0, 0, 0, ys1[i], vs1[i], (i < 9) ? 2 : ((i < 23) ? 3 : 1), 1, int'(i == 23));

        // Speed-tweaked launch, air jump, ignored third rise.
        tick(0, 0, 0, 0, 87, 0, 1, 1, 0);
        tick(1, 0, 0, 16, 75, -12, 2, 1, 0);
        tick(0, 0, 0, 0, 63, -12, 2, 1, 0);
        tick(1, 0, 0, 0, 53, -10, 2, 0, 0);
        tick(0, 0, 0, 0, 43, -5, 2, 0, 0);
        tick(1, 0, 0, 0, 39, -4, 2, 0, 0);
        for (int i = 0; i < 10; i++)
            tick(1, 0, 0, 0, ys2[i], vs2[i], (i < 6) ? 2 : 3, 0, 0);

        // Duck while falling at vel 2: entry tick, then doubled displacement, land into DUCKING.
        tick(1, 1, 0, 0, 30, 1, 4, 0, 0);
        tick(1, 1, 0, 0, 32, 1, 4, 0, 0);
        for (int i = 0; i < 8; i++)
            tick(1, 1, 0, 0, ys3[i], vs3[i], (i < 7) ? 4 : 5, (i < 7) ? 0 : 1, int'(i == 7));

        // DUCKING ignores rises; release returns to RUNNING; rise beats duck in RUNNING.
        tick(0, 1, 0, 0, 87, 0, 5, 1, 0);
        tick(1, 1, 0, 0, 87, 0, 5, 1, 0);
        tick(1, 0, 0, 0, 87, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 87, 0, 1, 1, 0);
        tick(1, 1, 0, 0, 77, -10, 2, 1, 0);

        // Crash mid-rise freezes everything until reset.
        tick(1, 0, 1, 0, 77, -10, 6, 1, 0);
        for (int i = 0; i < 10; i++)
            tick(logic'(i % 2), logic'(i == 4), 0, 31, 77, -10, 6, 1, 0);
        do_reset();
        tick(0, 1, 0, 0, 87, 0, 0, 1, 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
